// File: rtl/seq_detect_pkg.sv
// Shared types and reset constants for the serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Reset configuration: pattern 1101 right-aligned, len 4, overlapping.
  localparam logic [15:0] RST_PATTERN = 16'h000D;
  localparam int unsigned RST_LEN     = 4;
  localparam logic        RST_OVERLAP = 1'b1;

  // Width of a field able to hold 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host/config and serial-data bundle between the host side and the detector.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned WIN_W   = 8
) ();

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               data;
  logic               data_valid;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               done;
  logic               cfg_err;

  // Host / data source side.
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    output start, abort, data, data_valid,
    input  busy, match, match_count, done, cfg_err
  );

  // Detector side.
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    input  start, abort, data, data_valid,
    output busy, match, match_count, done, cfg_err
  );

endinterface

// File: rtl/seq_match_core.sv
// Shift register, fill tracking and length-masked pattern compare.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               data,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] sr_next_c;
  logic [LEN_W-1:0]   fill_next_c;
  logic [MAX_LEN-1:0] mask_c;

  // Evaluate the incoming bit against the pattern and compute next shift state.
  always_comb begin
    sr_next_c   = {sr_q[MAX_LEN-2:0], data};
    fill_next_c = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask_c      = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask_c[i] = (i < int'(len));
    end
    hit = (fill_next_c >= len) && ((sr_next_c & mask_c) == (pattern & mask_c));

    sr_d   = sr_q;
    fill_d = fill_q;
    if (clear) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (shift_en) begin
      sr_d   = sr_next_c;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      fill_d = (hit && !overlap) ? '0 : fill_next_c;
    end
  end

  // Shift register and fill state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned WIN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  sif
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               len_bad_c;
  logic               core_clear_c;
  logic               core_shift_c;
  logic               hit;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (core_clear_c),
    .shift_en (core_shift_c),
    .data     (sif.data),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

  // Next state, config capture, counters and registered output values.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    ovl_d        = ovl_q;
    win_d        = win_q;
    bit_d        = bit_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    match_d      = 1'b0;
    core_clear_c = 1'b0;
    core_shift_c = 1'b0;
    len_bad_c    = (len_q == '0) || (32'(len_q) > MAX_LEN);

    unique case (state_q)
      IDLE, DONE: begin
        if (sif.cfg_we) begin
          pat_d = sif.cfg_pattern;
          len_d = sif.cfg_len;
          ovl_d = sif.cfg_overlap;
          win_d = sif.cfg_window;
        end
        // Start is judged against the already latched length.
        if (sif.start && !sif.abort) begin
          if (len_bad_c) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = ARM;
          end
        end
      end

      ARM: begin
        if (sif.cfg_we) err_d = 1'b1;
        if (sif.abort) begin
          state_d = IDLE;
        end else begin
          core_clear_c = 1'b1;
          cnt_d        = '0;
          bit_d        = '0;
          state_d      = RUN;
        end
      end

      RUN: begin
        if (sif.cfg_we) err_d = 1'b1;
        if (sif.abort) begin
          state_d = IDLE;
        end else if (sif.data_valid) begin
          core_shift_c = 1'b1;
          bit_d        = bit_q + WIN_W'(1);
          if (hit) begin
            match_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end
          if ((win_q != '0) && (bit_d == win_q)) state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARM) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, configuration, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= MAX_LEN'(RST_PATTERN);
      len_q   <= LEN_W'(RST_LEN);
      ovl_q   <= RST_OVERLAP;
      win_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      match_q <= match_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sif.busy        = busy_q;
  assign sif.match       = match_q;
  assign sif.match_count = cnt_q;
  assign sif.done        = done_q;
  assign sif.cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed streams, queued match expectations.
module tb_seq_detect_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned WIN_W   = 8;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) sif ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every match pulse must correspond to the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sif.match === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_match: got pulse at cycle %0d count %0d, required no pulse",
                   cyc, sif.match_count);
        end else begin
          e = exp_q.pop_front();
          check("match_cycle", cyc, e.cyc);
          check("match_count_at_pulse", int'(sif.match_count), e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sif.data_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic d, input bit exp_m, input int exp_c);
    exp_t e;
    sif.data       = d;
    sif.data_valid = 1'b1;
    if (exp_m) begin
      e.cyc = cyc + 1;
      e.cnt = exp_c;
      exp_q.push_back(e);
    end
    tick();
    sif.data_valid = 1'b0;
  endtask

  task automatic gap();
    sif.data       = 1'b1;
    sif.data_valid = 1'b0;
    tick();
  endtask

  task automatic do_start();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic do_abort();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [7:0] win);
    sif.cfg_pattern = pat;
    sif.cfg_len     = len;
    sif.cfg_overlap = ovl;
    sif.cfg_window  = win;
    sif.cfg_we      = 1'b1;
    tick();
    sif.cfg_we = 1'b0;
  endtask

  task automatic check_drained(input string name);
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(sif.busy), 0);
    check({tag, "_match"}, int'(sif.match), 0);
    check({tag, "_count"}, int'(sif.match_count), 0);
    check({tag, "_done"}, int'(sif.done), 0);
    check({tag, "_cfg_err"}, int'(sif.cfg_err), 0);
  endtask

  initial begin
    logic [6:0] s1;
    sif.cfg_we = 0; sif.cfg_pattern = '0; sif.cfg_len = '0; sif.cfg_overlap = 0;
    sif.cfg_window = '0; sif.start = 0; sif.abort = 0; sif.data = 0; sif.data_valid = 0;
    s1 = 7'b1101101;

    // Reset defaults.
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Default config, overlapping: stream 1101101 matches at bits 4 and 7.
    do_start();
    sif.data = 1'b1; sif.data_valid = 1'b1;  // ARM cycle ignores data
    tick();
    for (int i = 6; i >= 0; i--)
      send(s1[i], (i == 3) || (i == 0), (i == 3) ? 1 : 2);
    check_drained("t1_drain");
    check("t1_busy", int'(sif.busy), 1);
    check("t1_done", int'(sif.done), 0);
    check("t1_count", int'(sif.match_count), 2);
    do_abort();
    check("t1_abort_busy", int'(sif.busy), 0);
    check("t1_abort_count_held", int'(sif.match_count), 2);

    // Same stream, non-overlapping: only the bit-4 match.
    do_cfg(8'h0D, 4'd4, 1'b0, 8'd0);
    do_start();
    idle(1);
    for (int i = 6; i >= 0; i--)
      send(s1[i], i == 3, 1);
    check_drained("t1b_drain");
    check("t1b_count", int'(sif.match_count), 1);
    do_abort();

    // Pattern 101, len 3, window 8, stream 10101010 with gaps.
    do_cfg(8'h05, 4'd3, 1'b1, 8'd8);
    do_start();
    idle(1);
    send(1, 0, 0); gap(); send(0, 0, 0); send(1, 1, 1); gap(); gap();
    send(0, 0, 0); send(1, 1, 2); send(0, 0, 0); gap(); send(1, 1, 3); gap();
    check("t2_busy_before_last", int'(sif.busy), 1);
    check("t2_done_before_last", int'(sif.done), 0);
    send(0, 0, 0);
    check("t2_done", int'(sif.done), 1);
    check("t2_busy_after", int'(sif.busy), 0);
    check("t2_count", int'(sif.match_count), 3);
    tick();
    check("t2_done_level", int'(sif.done), 1);
    check_drained("t2_drain");

    // Saturation: pattern 1, len 1, 20 ones (config and start from DONE).
    do_cfg(8'h01, 4'd1, 1'b1, 8'd0);
    do_start();
    idle(1);
    for (int i = 1; i <= 20; i++) send(1, 1, (i < 15) ? i : 15);
    check_drained("t3_drain");
    check("t3_count_sat", int'(sif.match_count), 15);
    do_abort();
    check("t3_abort_busy", int'(sif.busy), 0);

    // Illegal length: start refused, sticky error.
    do_cfg(8'h0D, 4'd0, 1'b1, 8'd0);
    do_start();
    check("t4_err", int'(sif.cfg_err), 1);
    check("t4_busy", int'(sif.busy), 0);
    tick();
    check("t4_busy_stay", int'(sif.busy), 0);
    do_cfg(8'h0D, 4'd4, 1'b1, 8'd0);
    check("t4_err_sticky", int'(sif.cfg_err), 1);
    do_start();
    check("t4_err_cleared", int'(sif.cfg_err), 0);
    check("t4_busy_arm", int'(sif.busy), 1);
    idle(1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);

    // Config write during RUN is refused and flagged.
    do_cfg(8'h00, 4'd2, 1'b0, 8'd0);
    check("t5_err", int'(sif.cfg_err), 1);
    check("t5_busy", int'(sif.busy), 1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 2);
    idle(1);
    sif.abort = 1'b1; sif.start = 1'b1;
    tick();
    sif.abort = 1'b0; sif.start = 1'b0;
    check("t5_abort_busy", int'(sif.busy), 0);
    check("t5_abort_done", int'(sif.done), 0);
    check("t5_abort_count", int'(sif.match_count), 2);
    tick();
    check("t5_start_ignored", int'(sif.busy), 0);
    check_drained("t5_drain");

    // Asynchronous reset mid-bit during RUN.
    do_cfg(8'h03, 4'd3, 1'b0, 8'd6);
    do_start();
    idle(1);
    send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
    do_cfg(8'hFF, 4'd2, 1'b1, 8'd0);
    check("t6_err_pre", int'(sif.cfg_err), 1);
    send(0, 0, 0); send(1, 0, 0);
    check("t6_count_pre", int'(sif.match_count), 1);
    sif.data = 1'b1; sif.data_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    sif.data_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("t6_release");
    idle(2);
    do_start();
    idle(1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    check_drained("t6_drain");
    check("t6_busy_unbounded", int'(sif.busy), 1);
    check("t6_count", int'(sif.match_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
